// File: rtl/sst_pkg.sv
// Shared types for the save-state sequencer.
// State encoding, transfer mode and default slot count.
package sst_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENTER,
    S_RD,
    S_WR,
    L_RD,
    L_WR,
    EXIT
  } sst_state_t;

  typedef enum logic {
    SAVE,
    LOAD
  } sst_mode_t;

  localparam int SST_AW_DEF = 6;
  localparam int SST_SLOTS  = 2 ** SST_AW_DEF;

endpackage

// File: rtl/sst_hold_timer.sv
// Phase hold timer for the save-state sequencer.
// Counts 0..HOLD-1 while enabled; restarted on every phase entry.
module sst_hold_timer #(
  parameter int HOLD = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int W = (HOLD > 1) ? $clog2(HOLD) : 1;

  logic [W-1:0] cnt_q;

  assign expire_o = en_i && (cnt_q == W'(HOLD - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (start_i) begin
      cnt_q <= '0;
    end else if (en_i && !expire_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/sst_sequencer.sv
// Save-state initiator: freezes the mapper and moves every sst slot
// between the mapper and the state memory.
module sst_sequencer
  import sst_pkg::*;
#(
  parameter int SST_AW   = 6,
  parameter int MEM_AW   = 10,
  parameter int MEM_BASE = 0,
  parameter int HOLD     = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_save,
  input  logic              start_load,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              sst_enable,
  output logic              sst_we,
  output logic [SST_AW-1:0] sst_addr,
  output logic [7:0]        sst_data_out,
  input  logic [7:0]        sst_data_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack
);

  localparam logic [SST_AW-1:0] LAST = '1;

  sst_state_t        state_q, state_d;
  sst_mode_t         mode_q, mode_d;
  logic [SST_AW-1:0] cnt_q, cnt_d;
  logic [7:0]        data_q, data_d;
  logic              abort_q, abort_d;
  logic              done_q, done_d;
  logic              slot_done;
  logic              tmr_start, tmr_en, expire;
  logic              in_slot;

  assign tmr_start = (state_d != state_q);
  assign tmr_en    = state_q inside {ENTER, S_RD, L_WR, EXIT};

  sst_hold_timer #(
    .HOLD(HOLD)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .start_i (tmr_start),
    .en_i    (tmr_en),
    .expire_o(expire)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    abort_d   = abort_q | abort;
    done_d    = 1'b0;
    slot_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        cnt_d   = '0;
        if (start_save) begin
          state_d = ENTER;
          mode_d  = SAVE;
        end else if (start_load) begin
          state_d = ENTER;
          mode_d  = LOAD;
        end
      end
      ENTER: if (expire) state_d = (mode_q == SAVE) ? S_RD : L_RD;
      S_RD: if (expire) begin
        data_d  = sst_data_in;
        state_d = S_WR;
      end
      S_WR: slot_done = mem_ack;
      L_RD: if (mem_ack) begin
        data_d  = mem_rdata;
        state_d = L_WR;
      end
      L_WR: slot_done = expire;
      EXIT: if (expire) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // abort_d already folds in this cycle's abort
    if (slot_done) begin
      if (cnt_q == LAST || abort_d) begin
        state_d = EXIT;
      end else begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (mode_q == SAVE) ? S_RD : L_RD;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mode_q  <= SAVE;
      cnt_q   <= '0;
      data_q  <= '0;
      abort_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      abort_q <= abort_d;
      done_q  <= done_d;
    end
  end

  assign in_slot      = state_q inside {S_RD, S_WR, L_RD, L_WR};
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign sst_enable   = busy;
  assign sst_we       = (state_q == L_WR);
  assign sst_addr     = in_slot ? cnt_q : '0;
  assign sst_data_out = sst_we ? data_q : '0;
  assign mem_req      = (state_q == S_WR) || (state_q == L_RD);
  assign mem_we       = (state_q == S_WR);
  assign mem_addr     = mem_req ? MEM_AW'(MEM_BASE) + MEM_AW'(cnt_q) : '0;
  assign mem_wdata    = mem_we ? data_q : '0;

endmodule

// File: tb/tb_sst_sequencer.sv
// Scoreboard bench for sst_sequencer.
// Stimulus pushes expected transfers; monitors pop and compare.
module tb_sst_sequencer;

  localparam int SST_AW   = 2;
  localparam int MEM_AW   = 10;
  localparam int MEM_BASE = 3;
  localparam int HOLD     = 4;

  logic              clk;
  logic              reset_n;
  logic              start_save;
  logic              start_load;
  logic              abort;
  logic              busy;
  logic              done;
  logic              sst_enable;
  logic              sst_we;
  logic [SST_AW-1:0] sst_addr;
  logic [7:0]        sst_data_out;
  logic [7:0]        sst_data_in;
  logic              mem_req;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ack;

  sst_sequencer #(
    .SST_AW  (SST_AW),
    .MEM_AW  (MEM_AW),
    .MEM_BASE(MEM_BASE),
    .HOLD    (HOLD)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_save  (start_save),
    .start_load  (start_load),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .sst_enable  (sst_enable),
    .sst_we      (sst_we),
    .sst_addr    (sst_addr),
    .sst_data_out(sst_data_out),
    .sst_data_in (sst_data_in),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack)
  );

  typedef struct {
    logic              we;
    logic [MEM_AW-1:0] addr;
    logic [7:0]        data;
  } mtx_t;

  typedef struct {
    logic [SST_AW-1:0] addr;
    logic [7:0]        data;
    int                len;
  } stx_t;

  mtx_t exp_mem[$];
  stx_t exp_sst[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cnt = 0;
  int   we_cycles = 0;
  int   ack_delay = 0;
  int   wcnt;
  logic [7:0] img [0:(2**MEM_AW)-1];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mapper slot n returns A0+n
  assign sst_data_in = 8'hA0 + 8'(sst_addr);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_ack   <= 1'b0;
      mem_rdata <= 8'h00;
      wcnt      <= 0;
    end else if (mem_req && !mem_ack) begin
      if (wcnt >= ack_delay) begin
        mem_ack <= 1'b1;
        wcnt    <= 0;
        if (!mem_we) mem_rdata <= img[mem_addr];
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      mem_ack <= 1'b0;
      wcnt    <= 0;
    end
  end

  mtx_t        m_pop;
  stx_t        s_pop;
  logic        pend_q = 1'b0;
  logic [18:0] pend_v;
  logic        we_prev = 1'b0;
  int          we_len;
  logic [SST_AW-1:0] we_addr;
  logic [7:0]  we_data;

  always @(negedge clk) begin
    if (reset_n) begin
      if (done) done_cnt++;
      if (mem_req && mem_ack) begin
        if (exp_mem.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL mem_unexpected: got addr %0h we %0b expected none", mem_addr, mem_we);
        end else begin
          m_pop = exp_mem.pop_front();
          chk("mem_we", 64'(mem_we), 64'(m_pop.we));
          chk("mem_addr", 64'(mem_addr), 64'(m_pop.addr));
          if (m_pop.we) chk("mem_wdata", 64'(mem_wdata), 64'(m_pop.data));
        end
      end
      if (pend_q && mem_req)
        chk("mem_stable", 64'({mem_we, mem_addr, mem_wdata}), 64'(pend_v));
      pend_q = mem_req && !mem_ack;
      pend_v = {mem_we, mem_addr, mem_wdata};
      if (sst_we) begin
        we_cycles++;
        if (!we_prev) begin
          we_len  = 1;
          we_addr = sst_addr;
          we_data = sst_data_out;
        end else begin
          we_len++;
          chk("sst_stable", 64'({sst_addr, sst_data_out}), 64'({we_addr, we_data}));
        end
      end else if (we_prev) begin
        if (exp_sst.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sst_unexpected: got addr %0h data %0h expected none", we_addr, we_data);
        end else begin
          s_pop = exp_sst.pop_front();
          chk("sst_addr", 64'(we_addr), 64'(s_pop.addr));
          chk("sst_data", 64'(we_data), 64'(s_pop.data));
          chk("sst_we_len", 64'(we_len), 64'(s_pop.len));
        end
      end
      we_prev = sst_we;
    end else begin
      pend_q  = 1'b0;
      we_prev = 1'b0;
    end
  end

  task automatic push_save(int n);
    for (int i = 0; i < n; i++)
      exp_mem.push_back('{1'b1, MEM_AW'(MEM_BASE + i), 8'hA0 + 8'(i)});
  endtask

  task automatic pulse_start(logic s, logic l);
    @(posedge clk);
    #1 start_save = s;
    start_load = l;
    @(posedge clk);
    #1 start_save = 1'b0;
    start_load = 1'b0;
  endtask

  task automatic wait_done(string name);
    for (int i = 0; i < 3000 && !done; i++) @(negedge clk);
    chk({name, "_done"}, 64'(done), 64'd1);
    chk({name, "_busy_at_done"}, 64'(busy), 64'd0);
  endtask

  task automatic finish_check(string name);
    repeat (4) @(negedge clk);
    chk({name, "_mem_left"}, 64'(exp_mem.size()), 64'd0);
    chk({name, "_sst_left"}, 64'(exp_sst.size()), 64'd0);
    chk({name, "_done_cnt"}, 64'(done_cnt), 64'd1);
    chk({name, "_idle"}, 64'({busy, sst_enable}), 64'd0);
  endtask

  initial begin
    reset_n    = 1'b0;
    start_save = 1'b0;
    start_load = 1'b0;
    abort      = 1'b0;
    for (int i = 0; i < 2 ** MEM_AW; i++) img[i] = 8'h00;
    img[3] = 8'h11;
    img[4] = 8'h22;
    img[5] = 8'h33;
    img[6] = 8'h44;
    repeat (3) @(negedge clk);
    chk("reset_outs", 64'({busy, done, sst_enable, sst_we, sst_addr, sst_data_out,
                           mem_req, mem_we, mem_addr, mem_wdata}), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_outs", 64'({busy, sst_enable, mem_req}), 64'd0);

    // simultaneous starts: save wins; a later load request is ignored
    done_cnt  = 0;
    we_cycles = 0;
    push_save(4);
    pulse_start(1'b1, 1'b1);
    chk("busy_rise", 64'(busy), 64'd1);
    repeat (6) @(posedge clk);
    #1 start_load = 1'b1;
    @(posedge clk);
    #1 start_load = 1'b0;
    wait_done("save");
    finish_check("save");
    chk("save_no_sst_we", 64'(we_cycles), 64'd0);

    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      exp_mem.push_back('{1'b0, MEM_AW'(MEM_BASE + i), 8'h00});
      exp_sst.push_back('{SST_AW'(i), img[MEM_BASE + i], HOLD});
    end
    pulse_start(1'b0, 1'b1);
    wait_done("load");
    finish_check("load");

    done_cnt = 0;
    push_save(2);
    pulse_start(1'b1, 1'b0);
    for (int i = 0; i < 500 && !(sst_enable && sst_addr == 2'd1 && !mem_req); i++)
      @(negedge clk);
    chk("abort_reach_slot1", 64'(sst_addr), 64'd1);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    wait_done("abort");
    finish_check("abort");

    done_cnt  = 0;
    ack_delay = 5;
    push_save(4);
    pulse_start(1'b1, 1'b0);
    wait_done("slow_ack");
    finish_check("slow_ack");
    ack_delay = 0;

    done_cnt = 0;
    exp_mem.push_back('{1'b0, MEM_AW'(MEM_BASE), 8'h00});
    pulse_start(1'b0, 1'b1);
    for (int i = 0; i < 500 && !sst_we; i++) @(negedge clk);
    chk("rst_reach_lwr", 64'(sst_we), 64'd1);
    #2 reset_n = 1'b0;
    #1 chk("rst_async", 64'({busy, sst_enable, sst_we, mem_req}), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_no_done", 64'(done_cnt), 64'd0);
    chk("rst_mem_left", 64'(exp_mem.size()), 64'd0);
    push_save(4);
    pulse_start(1'b1, 1'b0);
    wait_done("post_rst");
    finish_check("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
